// File: rtl/enum_toggle_checker_if.sv
// Bundles the sample stream and the verdict outputs of the enum toggle checker.
// The generator side uses the master modport, the checker uses the slave modport.
interface enum_toggle_checker_if;
  logic        enable;
  logic        enum_in;
  logic        locked;
  logic        error;
  logic        done;
  logic [15:0] match_count;
  logic [7:0]  error_count;

  modport master (
    output enable, enum_in,
    input  locked, error, done, match_count, error_count
  );

  modport slave (
    input  enable, enum_in,
    output locked, error, done, match_count, error_count
  );
endinterface

// File: rtl/enum_toggle_checker.sv
// Receive-side checker for a strictly alternating 1-bit enum stream: locks on,
// counts good toggles and violations, and latches done after TOGGLE_TARGET toggles.
module enum_toggle_checker #(
  parameter int TOGGLE_TARGET     = 8,
  parameter int MAX_CONSEC_ERRORS = 2
) (
  input logic                        clk,
  input logic                        reset,
  enum_toggle_checker_if.slave       bus
);

  typedef enum logic [7:0] {
    INITIAL = 8'd0,
    SYNC    = 8'd1,
    TRACK   = 8'd2,
    DONE    = 8'd3
  } state_t;

  localparam logic [15:0] TARGET  = 16'(TOGGLE_TARGET);
  localparam logic [7:0]  MAX_ERR = 8'(MAX_CONSEC_ERRORS);

  state_t      state, state_next;
  logic        last, last_next;
  logic [7:0]  consec, consec_next;
  logic        locked, locked_next;
  logic        error, error_next;
  logic        done, done_next;
  logic [15:0] match_count, match_next;
  logic [7:0]  error_count, errcnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INITIAL;
      last        <= 1'b0;
      consec      <= 8'd0;
      locked      <= 1'b0;
      error       <= 1'b0;
      done        <= 1'b0;
      match_count <= 16'd0;
      error_count <= 8'd0;
    end else begin
      state       <= state_next;
      last        <= last_next;
      consec      <= consec_next;
      locked      <= locked_next;
      error       <= error_next;
      done        <= done_next;
      match_count <= match_next;
      error_count <= errcnt_next;
    end
  end

  // error is a pulse, so it defaults low; everything else holds unless a rule fires
  always_comb begin
    state_next  = state;
    last_next   = last;
    consec_next = consec;
    locked_next = locked;
    error_next  = 1'b0;
    done_next   = done;
    match_next  = match_count;
    errcnt_next = error_count;

    case (state)
      INITIAL: begin
        match_next  = 16'd0;
        errcnt_next = 8'd0;
        consec_next = 8'd0;
        locked_next = 1'b0;
        done_next   = 1'b0;
        state_next  = SYNC;
      end
      SYNC: begin
        if (bus.enable) begin
          last_next   = bus.enum_in;
          locked_next = 1'b1;
          consec_next = 8'd0;
          match_next  = 16'd0;
          state_next  = TRACK;
        end
      end
      TRACK: begin
        if (bus.enable) begin
          last_next = bus.enum_in;
          if (bus.enum_in != last) begin
            match_next  = match_count + 16'd1;
            consec_next = 8'd0;
            if (match_next == TARGET) begin
              done_next  = 1'b1;
              state_next = DONE;
            end
          end else begin
            error_next  = 1'b1;
            consec_next = consec + 8'd1;
            if (error_count != 8'hFF) begin
              errcnt_next = error_count + 8'd1;
            end
            // error_count is cumulative, so only the lock is dropped here
            if (consec_next == MAX_ERR) begin
              locked_next = 1'b0;
              state_next  = SYNC;
            end
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_next = INITIAL;
      end
    endcase
  end

  assign bus.locked      = locked;
  assign bus.error       = error;
  assign bus.done        = done;
  assign bus.match_count = match_count;
  assign bus.error_count = error_count;

endmodule

// File: tb/tb_enum_toggle_checker.sv
// Drives two checker instances (different parameters) with shared directed and
// random streams and compares every output each cycle against a flag-based model.
module tb_enum_toggle_checker;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  always #5 clk = ~clk;

  enum_toggle_checker_if bus_a ();
  enum_toggle_checker_if bus_b ();

  enum_toggle_checker #(.TOGGLE_TARGET(8), .MAX_CONSEC_ERRORS(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  enum_toggle_checker #(.TOGGLE_TARGET(4), .MAX_CONSEC_ERRORS(255)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  int   m_tt  [2] = '{8, 4};
  int   m_mce [2] = '{2, 255};
  bit   m_init   [2];
  bit   m_locked [2];
  bit   m_done   [2];
  bit   m_error  [2];
  bit   m_last   [2];
  int   m_consec [2];
  int   m_matches[2];
  int   m_errors [2];

  // Behavioural reference: a stream is either waiting to start, hunting for a
  // reference sample, tracking alternation, or finished.
  task automatic model_edge(input int i, input bit rst, input bit en, input bit v);
    m_error[i] = 0;
    if (rst) begin
      m_init[i] = 1; m_locked[i] = 0; m_done[i] = 0;
      m_matches[i] = 0; m_errors[i] = 0; m_consec[i] = 0; m_last[i] = 0;
    end else if (m_init[i]) begin
      m_init[i] = 0; m_locked[i] = 0; m_done[i] = 0;
      m_matches[i] = 0; m_errors[i] = 0; m_consec[i] = 0;
    end else if (m_done[i] || !en) begin
    end else if (!m_locked[i]) begin
      m_last[i] = v; m_locked[i] = 1; m_consec[i] = 0; m_matches[i] = 0;
    end else begin
      if (v != m_last[i]) begin
        m_matches[i]++;
        m_consec[i] = 0;
        if (m_matches[i] == m_tt[i]) m_done[i] = 1;
      end else begin
        m_error[i] = 1;
        if (m_errors[i] < 255) m_errors[i]++;
        m_consec[i]++;
        if (m_consec[i] == m_mce[i]) m_locked[i] = 0;
      end
      m_last[i] = v;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic compare_model(input int i, input logic lk, input logic er, input logic dn,
                               input logic [15:0] mc, input logic [7:0] ec);
    string n = (i == 0) ? "a" : "b";
    checkOutput({n, ".locked"},      {31'd0, lk}, {31'd0, m_locked[i]});
    checkOutput({n, ".error"},       {31'd0, er}, {31'd0, m_error[i]});
    checkOutput({n, ".done"},        {31'd0, dn}, {31'd0, m_done[i]});
    checkOutput({n, ".match_count"}, {16'd0, mc}, 32'(m_matches[i]));
    checkOutput({n, ".error_count"}, {24'd0, ec}, 32'(m_errors[i]));
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit v);
    reset = rst;
    bus_a.enable = en; bus_a.enum_in = v;
    bus_b.enable = en; bus_b.enum_in = v;
    @(posedge clk);
    cycle++;
    model_edge(0, rst, en, v);
    model_edge(1, rst, en, v);
    #1;
    compare_model(0, bus_a.locked, bus_a.error, bus_a.done, bus_a.match_count, bus_a.error_count);
    compare_model(1, bus_b.locked, bus_b.error, bus_b.done, bus_b.match_count, bus_b.error_count);
  endtask

  // Two reset edges followed by the one edge the checker spends before hunting.
  task automatic restart();
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
  endtask

  initial begin
    int  fall_at;
    int  n_en;
    bit  prev_lk;
    bit  v;
    bit  seq [$];

    // Clean stream: lock 2 edges after reset, done 8 edges after lock on dut_a.
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("reset.a_locked", {31'd0, bus_a.locked}, 32'd0);
    checkOutput("reset.a_count",  {16'd0, bus_a.match_count}, 32'd0);
    applyStimulus(0, 1, 1);
    checkOutput("clean.lock_edge1", {31'd0, bus_a.locked}, 32'd0);
    applyStimulus(0, 1, 0);
    checkOutput("clean.lock_edge2", {31'd0, bus_a.locked}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 1, k[0]);
      checkOutput("clean.done_time", {31'd0, bus_a.done}, (k == 8) ? 32'd1 : 32'd0);
    end
    checkOutput("clean.a_matches", {16'd0, bus_a.match_count}, 32'd8);
    checkOutput("clean.a_errors",  {24'd0, bus_a.error_count}, 32'd0);

    // Single glitch: 0,1,0,0,1,0,1
    restart();
    seq = '{0, 1, 0, 0, 1, 0, 1};
    foreach (seq[k]) applyStimulus(0, 1, seq[k]);
    checkOutput("glitch.a_errors",  {24'd0, bus_a.error_count}, 32'd1);
    checkOutput("glitch.a_locked",  {31'd0, bus_a.locked}, 32'd1);
    checkOutput("glitch.a_matches", {16'd0, bus_a.match_count}, 32'd5);

    // Loss of lock: 0,1,1,1,0,1
    restart();
    seq = '{0, 1, 1, 1};
    foreach (seq[k]) applyStimulus(0, 1, seq[k]);
    checkOutput("lol.a_dropped", {31'd0, bus_a.locked}, 32'd0);
    checkOutput("lol.a_pulse",   {31'd0, bus_a.error}, 32'd1);
    applyStimulus(0, 1, 0);
    checkOutput("lol.a_relock",  {31'd0, bus_a.locked}, 32'd1);
    checkOutput("lol.a_cleared", {16'd0, bus_a.match_count}, 32'd0);
    applyStimulus(0, 1, 1);
    checkOutput("lol.a_errors",  {24'd0, bus_a.error_count}, 32'd2);
    checkOutput("lol.a_matches", {16'd0, bus_a.match_count}, 32'd1);

    // Enable gaps: dut_b (target 4) finishes after capture plus 4 enabled toggles.
    restart();
    for (int j = 0; j < 5; j++) begin
      applyStimulus(0, 1, j[0]);
      for (int g = 0; g < 3; g++) applyStimulus(0, 0, 1'($urandom));
    end
    checkOutput("gap.b_done",    {31'd0, bus_b.done}, 32'd1);
    checkOutput("gap.b_matches", {16'd0, bus_b.match_count}, 32'd4);
    checkOutput("gap.b_errors",  {24'd0, bus_b.error_count}, 32'd0);

    // Saturation: constant 1, lock drops on the 255th violation (256th sample).
    restart();
    fall_at = 0;
    for (int k = 1; k <= 300; k++) begin
      prev_lk = bus_b.locked;
      applyStimulus(0, 1, 1);
      if (prev_lk && !bus_b.locked && fall_at == 0) fall_at = k;
    end
    checkOutput("sat.b_fall_at", 32'(fall_at), 32'd256);
    checkOutput("sat.b_errors",  {24'd0, bus_b.error_count}, 32'd255);

    // Sticky done: both instances finish, then random input must not move anything.
    restart();
    for (int k = 0; k < 10; k++) applyStimulus(0, 1, k[0]);
    for (int k = 0; k < 40; k++) applyStimulus(0, 1'($urandom), 1'($urandom));
    checkOutput("frozen.a_matches", {16'd0, bus_a.match_count}, 32'd8);
    checkOutput("frozen.b_matches", {16'd0, bus_b.match_count}, 32'd4);
    checkOutput("frozen.a_locked",  {31'd0, bus_a.locked}, 32'd1);
    checkOutput("frozen.b_done",    {31'd0, bus_b.done}, 32'd1);

    // Reset mid-track with match_count=5, then restart from INITIAL.
    restart();
    for (int k = 0; k < 6; k++) applyStimulus(0, 1, k[0]);
    checkOutput("midrst.a_before", {16'd0, bus_a.match_count}, 32'd5);
    applyStimulus(1, 1, 0);
    checkOutput("midrst.a_matches", {16'd0, bus_a.match_count}, 32'd0);
    checkOutput("midrst.b_done",    {31'd0, bus_b.done}, 32'd0);
    applyStimulus(0, 1, 1);
    checkOutput("midrst.a_init", {31'd0, bus_a.locked}, 32'd0);
    applyStimulus(0, 1, 0);
    checkOutput("midrst.a_relock", {31'd0, bus_a.locked}, 32'd1);

    // Random mostly-alternating stream with occasional glitches and resets.
    v = 0;
    n_en = 0;
    for (int k = 0; k < 3000; k++) begin
      bit en;
      en = ($urandom_range(3) != 0);
      if (en) begin
        v = ($urandom_range(7) != 0) ? ~v : v;
        n_en++;
      end
      applyStimulus(($urandom_range(149) == 0), en, en ? v : 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout cycle=%0d", cycle);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/enum_toggle_checker.md
# enum_toggle_checker

Receive-side checker for a 1-bit two-value enum stream (Foo: 0/1) driven by a toggling generator FSM that inverts its output every cycle after start. The block locks onto the stream, verifies strict alternation cycle by cycle, and counts good toggles and violations. It completes after a programmable number of good toggles. It sits at the consumer end of the generator's output in VSharp unit-test benches and gives a self-checking pass/fail verdict.

## Interface
- TOGGLE_TARGET, default 8: good toggles required before `done` asserts; legal range 1..65535.
- MAX_CONSEC_ERRORS, default 2: consecutive violations that drop lock; legal range 1..255.
- clk  input  1  Single clock; all state changes on posedge.
- reset  input  1  Synchronous, active-high; sampled on posedge clk.
- enable  input  1  Sample qualifier; `enum_in` is ignored in cycles where enable=0.
- enum_in  input  1  Foo enum value from the generator.
- locked  output  1  Reference value captured; alternation being tracked.
- error  output  1  One-cycle pulse per detected violation.
- done  output  1  Sticky; TOGGLE_TARGET good toggles seen.
- match_count  output  16  Good toggles since the last lock.
- error_count  output  8  Total violations since reset; saturates at 255.

## Operation
- Registered state, 8-bit encoding:
  - INITIAL=0
  - SYNC=1
  - TRACK=2
  - DONE=3
- Internal registers:
  - `last` (1 bit): previous sampled value.
  - `consec` (8 bits): consecutive violations.
- INITIAL:
  - Clear `match_count`, `error_count`, `consec`, `locked`, `done`, and `error`.
  - Go to SYNC on the next edge unconditionally.
- SYNC:
  - If enable=1: `last`<=enum_in, `locked`<=1, `consec`<=0, `match_count`<=0, go to TRACK.
  - If enable=0: hold.
- TRACK, only when enable=1:
  - If enum_in != `last`: `match_count`+1, `consec`<=0.
  - If the new `match_count` equals TOGGLE_TARGET, go to DONE and set `done`<=1.
  - If enum_in == `last`: this is a violation. Pulse `error`<=1, `error_count`+1 (saturating), `consec`+1.
  - If the new `consec` equals MAX_CONSEC_ERRORS, go to SYNC and set `locked`<=0.
  - `last`<=enum_in in every enabled cycle, whether match or violation.
- TRACK with enable=0: hold all state; `error`<=0.
- DONE:
  - All outputs frozen; `done`=1 and `locked`=1 hold until reset.
  - `enum_in` and `enable` are ignored.
- `error` is 0 in every cycle that is not an enabled TRACK violation.
- `match_count` never wraps: DONE is reached at TOGGLE_TARGET ≤ 65535.
- Match and violation are mutually exclusive in a cycle, so counters never update simultaneously.

## Timing
- All outputs are registered and update on the posedge following the sampled edge, i.e. 1-cycle latency.
- Reset values, applied on the first posedge with reset=1:
  - locked=0, error=0, done=0, match_count=0, error_count=0.
  - State = INITIAL.
- After reset deasserts, the block needs 1 cycle in INITIAL before SYNC.
  - The earliest capture is 2 edges after reset falls; `locked` rises on that edge.
- The first toggle is counted at the enabled edge after capture.
  - With enable held at 1, `done` rises exactly TOGGLE_TARGET edges after `locked`.
- Reset mid-operation from any state, including DONE: the next edge returns to INITIAL with all outputs at reset values.
- Reset has priority over every other transition.
- Loss of lock: `locked` falls on the same edge that registers the MAX_CONSEC_ERRORS-th violation, and `error` pulses on that edge.
  - Re-capture occurs at the next enabled edge in SYNC.
- enable gaps do not break alternation: `last` spans the gap.

## Test plan
- Clean stream:
  - Stimulus: reset 2 cycles, enable=1, enum_in = 0,1,0,1,… with TOGGLE_TARGET=8.
  - Required: `locked` rises 2 edges after reset; `done` rises 8 edges later; match_count=8, error_count=0, no `error` pulse.
- Single glitch:
  - Stimulus: stream 0,1,0,0,1,0,… with MAX_CONSEC_ERRORS=2.
  - Required: one `error` pulse on the repeated 0; error_count=1; `locked` stays 1; tracking continues and match_count keeps incrementing.
- Loss of lock:
  - Stimulus: stream 0,1,1,1,0,1,….
  - Required: two error pulses; `locked` falls on the second; match_count clears at recapture; error_count=2; lock reacquired on the next sample.
- enable gaps:
  - Stimulus: pattern 0,(gap 3 cycles),1,(gap),0,… with TOGGLE_TARGET=4.
  - Required: no errors; match_count counts only enabled samples; `done` after the 4th enabled toggle.
- Saturation and sticky done:
  - Stimulus: MAX_CONSEC_ERRORS=255, constant enum_in=1 for 300 enabled cycles.
  - Required: error_count holds at 255; `locked` drops exactly on the 255th violation.
  - Then drive a clean stream to DONE and toggle `enum_in` randomly: outputs stay frozen.
- Reset mid-track:
  - Stimulus: assert reset with match_count=5.
  - Required: next edge gives all outputs 0; the sequence restarts from INITIAL.
